// File: rtl/mem_arbiter_if.sv
// Bundle of the I-side, D-side and physical-memory signals around mem_arbiter.
// master is the arbiter's view; slave is the view of the caches and memory around it.
interface mem_arbiter_if #(
   parameter int unsigned LINE_W = 256,
   parameter int unsigned ADDR_W = 32
);
   logic              i_read;
   logic [ADDR_W-1:0] i_address;
   logic [LINE_W-1:0] i_rdata;
   logic              i_resp;

   logic              d_read;
   logic              d_write;
   logic [ADDR_W-1:0] d_address;
   logic [LINE_W-1:0] d_wdata;
   logic [LINE_W-1:0] d_rdata;
   logic              d_resp;

   logic              pmem_read;
   logic              pmem_write;
   logic [ADDR_W-1:0] pmem_address;
   logic [LINE_W-1:0] pmem_wdata;
   logic [LINE_W-1:0] pmem_rdata;
   logic              pmem_resp;

   modport master (
      input  i_read, i_address,
      output i_rdata, i_resp,
      input  d_read, d_write, d_address, d_wdata,
      output d_rdata, d_resp,
      output pmem_read, pmem_write, pmem_address, pmem_wdata,
      input  pmem_rdata, pmem_resp
   );

   modport slave (
      output i_read, i_address,
      input  i_rdata, i_resp,
      output d_read, d_write, d_address, d_wdata,
      input  d_rdata, d_resp,
      input  pmem_read, pmem_write, pmem_address, pmem_wdata,
      output pmem_rdata, pmem_resp
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter serializing I-side fills and D-side fills/writebacks onto
// one physical-memory port; each transaction runs to completion.
module mem_arbiter #(
   parameter int unsigned LINE_W = 256,
   parameter int unsigned ADDR_W = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   mem_arbiter_if.master bus
);
   localparam int unsigned OFS_W = $clog2(LINE_W / 8);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SERVE_I = 3'd1,
      SERVE_D = 3'd2,
      RESP_I  = 3'd3,
      RESP_D  = 3'd4
   } state_t;

   state_t            state;
   logic              rr_d;
   logic              is_wr_q;
   logic              pmem_read_q;
   logic              pmem_write_q;
   logic              i_resp_q;
   logic              d_resp_q;
   logic [ADDR_W-1:0] addr_q;
   logic [LINE_W-1:0] wdata_q;
   logic [LINE_W-1:0] rdata_q;

   logic i_req_c;
   logic d_req_c;
   logic grant_d_c;

   // D wins when it is alone or when the round-robin pointer favours it on a tie.
   assign i_req_c   = bus.i_read;
   assign d_req_c   = bus.d_read | bus.d_write;
   assign grant_d_c = d_req_c & (~i_req_c | rr_d);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         rr_d         <= 1'b0;
         is_wr_q      <= 1'b0;
         pmem_read_q  <= 1'b0;
         pmem_write_q <= 1'b0;
         i_resp_q     <= 1'b0;
         d_resp_q     <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_d_c) begin
                  state        <= SERVE_D;
                  addr_q       <= {bus.d_address[ADDR_W-1:OFS_W], OFS_W'(0)};
                  wdata_q      <= bus.d_wdata;
                  // a simultaneous read+write is issued as a writeback
                  is_wr_q      <= bus.d_write;
                  pmem_write_q <= bus.d_write;
                  pmem_read_q  <= ~bus.d_write;
               end else if (i_req_c) begin
                  state        <= SERVE_I;
                  addr_q       <= {bus.i_address[ADDR_W-1:OFS_W], OFS_W'(0)};
                  is_wr_q      <= 1'b0;
                  pmem_write_q <= 1'b0;
                  pmem_read_q  <= 1'b1;
               end
            end
            SERVE_I: begin
               if (bus.pmem_resp) begin
                  state        <= RESP_I;
                  rdata_q      <= bus.pmem_rdata;
                  pmem_read_q  <= 1'b0;
                  pmem_write_q <= 1'b0;
                  i_resp_q     <= 1'b1;
                  rr_d         <= 1'b1;
               end
            end
            SERVE_D: begin
               if (bus.pmem_resp) begin
                  state <= RESP_D;
                  if (!is_wr_q) begin
                     rdata_q <= bus.pmem_rdata;
                  end
                  pmem_read_q  <= 1'b0;
                  pmem_write_q <= 1'b0;
                  d_resp_q     <= 1'b1;
                  rr_d         <= 1'b0;
               end
            end
            RESP_I: begin
               state    <= IDLE;
               i_resp_q <= 1'b0;
            end
            RESP_D: begin
               state    <= IDLE;
               d_resp_q <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.pmem_read    = pmem_read_q;
   assign bus.pmem_write   = pmem_write_q;
   assign bus.pmem_address = addr_q;
   assign bus.pmem_wdata   = wdata_q;
   assign bus.i_resp       = i_resp_q;
   assign bus.d_resp       = d_resp_q;
   assign bus.i_rdata      = rdata_q;
   assign bus.d_rdata      = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table plus hand-written
// sequences for input churn, mid-transaction reset and arbitration after reset.
module tb_mem_arbiter;
   localparam int unsigned LW = 256;
   localparam int unsigned AW = 32;

   localparam logic [LW-1:0] PA5 = {32{8'hA5}};
   localparam logic [LW-1:0] PP  = {4{64'h0123_4567_89AB_CDEF}};
   localparam logic [LW-1:0] PP2 = {8{32'hCAFE_F00D}};
   localparam logic [LW-1:0] PW  = {8{32'h5A5A_0F0F}};
   localparam logic [LW-1:0] R1  = {8{32'h1111_0001}};
   localparam logic [LW-1:0] R2  = {8{32'h2222_0002}};
   localparam logic [LW-1:0] R3  = {8{32'h3333_0003}};

   typedef struct {
      logic          ir, dr, dw;
      logic [AW-1:0] ia, da;
      logic [LW-1:0] wd;
      logic          pr;
      logic [LW-1:0] prd;
      logic          er, ew;
      logic [AW-1:0] ea;
      logic [LW-1:0] ewd;
      logic          eir, edr;
      logic          crd;
      logic [LW-1:0] erd;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   vec_t vecs[$];

   mem_arbiter_if #(.LINE_W(LW), .ADDR_W(AW)) bus ();

   mem_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic add(input logic ir, dr, dw, input logic [AW-1:0] ia, da,
                      input logic [LW-1:0] wd, input logic pr, input logic [LW-1:0] prd,
                      input logic er, ew, input logic [AW-1:0] ea, input logic [LW-1:0] ewd,
                      input logic eir, edr, crd, input logic [LW-1:0] erd);
      vec_t v;
      v.ir = ir; v.dr = dr; v.dw = dw; v.ia = ia; v.da = da; v.wd = wd;
      v.pr = pr; v.prd = prd; v.er = er; v.ew = ew; v.ea = ea; v.ewd = ewd;
      v.eir = eir; v.edr = edr; v.crd = crd; v.erd = erd;
      vecs.push_back(v);
   endtask

   task automatic idle_inputs();
      bus.i_read = 1'b0; bus.i_address = '0;
      bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_address = '0; bus.d_wdata = '0;
      bus.pmem_rdata = '0; bus.pmem_resp = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " pmem_read"},  LW'(bus.pmem_read),  '0);
      chk({tag, " pmem_write"}, LW'(bus.pmem_write), '0);
      chk({tag, " pmem_addr"},  LW'(bus.pmem_address), '0);
      chk({tag, " pmem_wdata"}, bus.pmem_wdata, '0);
      chk({tag, " i_resp"},     LW'(bus.i_resp), '0);
      chk({tag, " d_resp"},     LW'(bus.d_resp), '0);
      chk({tag, " i_rdata"},    bus.i_rdata, '0);
      chk({tag, " d_rdata"},    bus.d_rdata, '0);
   endtask

   initial begin
      // One row per cycle: inputs applied, then outputs after the sampling edge.
      //   ir dr dw ia           da           wd   pr prd  er ew ea           ewd  eir edr crd erd
      // I-only fill, memory responds in cycle 3
      add(1, 0, 0, 32'h0000_1234, 0, 0,    0, 0,   1, 0, 32'h0000_1220, 0,   0, 0, 0, 0);
      add(1, 0, 0, 32'h0000_1234, 0, 0,    0, 0,   1, 0, 32'h0000_1220, 0,   0, 0, 0, 0);
      add(1, 0, 0, 32'h0000_1234, 0, 0,    0, 0,   1, 0, 32'h0000_1220, 0,   0, 0, 0, 0);
      add(1, 0, 0, 32'h0000_1234, 0, 0,    1, PA5, 0, 0, 0,             0,   1, 0, 1, PA5);
      add(0, 0, 0, 0,             0, 0,    0, 0,   0, 0, 0,             0,   0, 0, 0, 0);
      // D writeback
      add(0, 0, 1, 0, 32'h8000_003F, PP,   0, 0,   0, 1, 32'h8000_0020, PP,  0, 0, 0, 0);
      add(0, 0, 1, 0, 32'h8000_003F, PP,   1, R3,  0, 0, 0,             0,   0, 1, 0, 0);
      add(0, 0, 0, 0, 0,             0,    0, 0,   0, 0, 0,             0,   0, 0, 0, 0);
      // tie with rr_d=0: I first, then D on the next tie, then I again
      add(1, 1, 0, 32'h0000_0100, 32'h0000_0200, 0, 0, 0,  1, 0, 32'h0000_0100, 0, 0, 0, 0, 0);
      add(1, 1, 0, 32'h0000_0100, 32'h0000_0200, 0, 1, R1, 0, 0, 0,             0, 1, 0, 1, R1);
      add(0, 1, 0, 0,             32'h0000_0200, 0, 0, 0,  0, 0, 0,             0, 0, 0, 0, 0);
      add(1, 1, 0, 32'h0000_0100, 32'h0000_0200, 0, 0, 0,  1, 0, 32'h0000_0200, 0, 0, 0, 0, 0);
      add(1, 1, 0, 32'h0000_0100, 32'h0000_0200, 0, 1, R2, 0, 0, 0,             0, 0, 1, 1, R2);
      add(1, 0, 0, 32'h0000_0100, 0,             0, 0, 0,  0, 0, 0,             0, 0, 0, 0, 0);
      add(1, 1, 0, 32'h0000_0100, 32'h0000_0200, 0, 0, 0,  1, 0, 32'h0000_0100, 0, 0, 0, 0, 0);
      add(1, 1, 0, 32'h0000_0100, 32'h0000_0200, 0, 1, R3, 0, 0, 0,             0, 1, 0, 1, R3);
      add(0, 0, 0, 0,             0,             0, 0, 0,  0, 0, 0,             0, 0, 0, 0, 0);
      // read+write together is a writeback
      add(0, 1, 1, 0, 32'h0000_0047, PP2,  0, 0,   0, 1, 32'h0000_0040, PP2, 0, 0, 0, 0);
      add(0, 1, 1, 0, 32'h0000_0047, PP2,  1, R1,  0, 0, 0,             0,   0, 1, 0, 0);
      add(0, 0, 0, 0, 0,             0,    0, 0,   0, 0, 0,             0,   0, 0, 0, 0);
      // stray pmem_resp in IDLE
      add(0, 0, 0, 0, 0,             0,    1, R2,  0, 0, 0,             0,   0, 0, 0, 0);

      rst_n = 1'b0;
      idle_inputs();
      #3;
      chk_all_zero("reset");
      tick();
      rst_n = 1'b1;

      for (int k = 0; k < vecs.size(); k++) begin
         bus.i_read     = vecs[k].ir;
         bus.d_read     = vecs[k].dr;
         bus.d_write    = vecs[k].dw;
         bus.i_address  = vecs[k].ia;
         bus.d_address  = vecs[k].da;
         bus.d_wdata    = vecs[k].wd;
         bus.pmem_resp  = vecs[k].pr;
         bus.pmem_rdata = vecs[k].prd;
         tick();
         chk($sformatf("v%0d pmem_read", k),  LW'(bus.pmem_read),  LW'(vecs[k].er));
         chk($sformatf("v%0d pmem_write", k), LW'(bus.pmem_write), LW'(vecs[k].ew));
         chk($sformatf("v%0d i_resp", k),     LW'(bus.i_resp),     LW'(vecs[k].eir));
         chk($sformatf("v%0d d_resp", k),     LW'(bus.d_resp),     LW'(vecs[k].edr));
         if (vecs[k].er || vecs[k].ew)
            chk($sformatf("v%0d pmem_addr", k), LW'(bus.pmem_address), LW'(vecs[k].ea));
         if (vecs[k].ew)
            chk($sformatf("v%0d pmem_wdata", k), bus.pmem_wdata, vecs[k].ewd);
         if (vecs[k].crd && vecs[k].eir)
            chk($sformatf("v%0d i_rdata", k), bus.i_rdata, vecs[k].erd);
         if (vecs[k].crd && vecs[k].edr)
            chk($sformatf("v%0d d_rdata", k), bus.d_rdata, vecs[k].erd);
      end
      idle_inputs();

      // D inputs churn during SERVE_D; latched address/data must hold
      bus.d_write = 1'b1; bus.d_address = 32'h1000_0ABC; bus.d_wdata = PW;
      tick();
      for (int c = 0; c < 3; c++) begin
         bus.d_address = $urandom;
         bus.d_wdata   = {8{$urandom}};
         tick();
         chk($sformatf("churn%0d pmem_write", c), LW'(bus.pmem_write), LW'(1'b1));
         chk($sformatf("churn%0d pmem_addr", c),  LW'(bus.pmem_address), LW'(32'h1000_0AA0));
         chk($sformatf("churn%0d pmem_wdata", c), bus.pmem_wdata, PW);
      end
      bus.pmem_resp = 1'b1;
      tick();
      chk("churn d_resp", LW'(bus.d_resp), LW'(1'b1));
      chk("churn pmem_write_drop", LW'(bus.pmem_write), '0);
      idle_inputs();
      tick();

      // plain I fill leaves rr_d=1 so the post-reset grant below is meaningful
      bus.i_read = 1'b1; bus.i_address = 32'h0000_0040;
      tick();
      bus.pmem_resp = 1'b1; bus.pmem_rdata = R1;
      tick();
      chk("pre i_resp", LW'(bus.i_resp), LW'(1'b1));
      idle_inputs();
      tick();

      // reset two cycles into SERVE_I
      bus.i_read = 1'b1; bus.i_address = 32'h0000_2000;
      tick();
      tick();
      chk("mid pmem_read", LW'(bus.pmem_read), LW'(1'b1));
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero("async");
      bus.pmem_resp = 1'b1; bus.pmem_rdata = R2;
      tick();
      chk("rst no i_resp", LW'(bus.i_resp), '0);
      chk("rst no pmem_read", LW'(bus.pmem_read), '0);
      bus.pmem_resp = 1'b0;
      bus.d_read = 1'b1; bus.d_address = 32'h0000_3000;
      rst_n = 1'b1;
      tick();
      chk("post rst pmem_read", LW'(bus.pmem_read), LW'(1'b1));
      chk("post rst grant", LW'(bus.pmem_address), LW'(32'h0000_2000));
      bus.pmem_resp = 1'b1; bus.pmem_rdata = R3;
      tick();
      chk("post rst i_resp", LW'(bus.i_resp), LW'(1'b1));
      chk("post rst d_resp", LW'(bus.d_resp), '0);
      chk("post rst i_rdata", bus.i_rdata, R3);
      idle_inputs();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
